iqft_engine: RTL and testbench

// Inverse 3-qubit QFT: takes the 8 complex amplitudes of a state in the Fourier basis and returns the
// 8 computational-basis amplitudes. It undoes the forward QFT datapath and closes the round-trip check
// of our QFT coefficients. Time-multiplexed: one complex MAC per cycle, stream in, compute, stream out.
// out[k] = (1/sqrt8) * sum_j in[j] * W^(-j*k), W = e^(i*2*pi/8); index bit2 = MSB qubit.

---
 rtl/iqft_engine_if.sv | 24 ++
 rtl/iqft_engine.sv | 169 ++++++++++++++++
 tb/tb_iqft_engine.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iqft_engine_if.sv
// Stream interface for the inverse QFT engine: amplitude input stream, result output stream and status.
interface iqft_engine_if #(parameter int DW = 17);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [2:0]           out_idx;
  logic                 out_last;
  logic                 busy;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
  );
endinterface

// File: rtl/iqft_engine.sv
// Time-multiplexed 3-qubit inverse QFT: loads 8 complex amplitudes, runs one complex MAC per cycle
// (8 MACs plus one scale step per output), then streams the 8 scaled results.
module iqft_engine #(
  parameter int DW    = 17,
  parameter int SCALE = 11585,
  parameter int RT2   = 23170
) (
  input logic        clk,
  input logic        rst_n,
  iqft_engine_if.slave io
);
  localparam int AW = DW + 3;
  localparam int PW = AW + DW;
  localparam int FB = DW - 2;

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  localparam logic signed [DW-1:0] ONE = DW'(32'sd1 <<< FB);
  localparam logic signed [DW-1:0] R2  = DW'(RT2);
  localparam logic signed [DW-1:0] SC  = DW'(SCALE);
  localparam logic signed [PW-1:0] HI  = PW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] LO  = PW'(-(64'sd1 <<< (DW - 1)));

  logic [1:0]           state;
  logic [2:0]           load_cnt;
  logic [2:0]           k_cnt;
  logic [2:0]           out_cnt;
  logic [3:0]           step;
  logic signed [AW-1:0] acc_re;
  logic signed [AW-1:0] acc_im;

  logic signed [DW-1:0] in_re_buf  [8];
  logic signed [DW-1:0] in_im_buf  [8];
  logic signed [DW-1:0] out_re_buf [8];
  logic signed [DW-1:0] out_im_buf [8];

  logic                   scale_step;
  logic [2:0]             j_idx;
  logic [2:0]             m;
  logic signed [DW-1:0]   tw_c;
  logic signed [DW-1:0]   tw_s;
  logic signed [DW-1:0]   a;
  logic signed [DW-1:0]   b;
  logic signed [2*DW-1:0] p_ac;
  logic signed [2*DW-1:0] p_bs;
  logic signed [2*DW-1:0] p_as;
  logic signed [2*DW-1:0] p_bc;
  logic signed [AW-1:0]   acc_re_next;
  logic signed [AW-1:0]   acc_im_next;
  logic signed [PW-1:0]   sc_re;
  logic signed [PW-1:0]   sc_im;
  logic signed [DW-1:0]   res_re;
  logic signed [DW-1:0]   res_im;

  function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] s;
    s = x >>> FB;
    if (s > HI) return DW'(HI);
    if (s < LO) return DW'(LO);
    return DW'(s);
  endfunction

  assign scale_step = step[3];
  assign j_idx      = step[2:0];
  assign m          = j_idx * k_cnt;
  assign a          = in_re_buf[j_idx];
  assign b          = in_im_buf[j_idx];

  // Twiddle W^-m on the unit circle, indexed by (j*k) mod 8
  always_comb begin
    tw_c = ONE;
    tw_s = '0;
    case (m)
      3'd0: begin tw_c = ONE;  tw_s = '0;   end
      3'd1: begin tw_c = R2;   tw_s = -R2;  end
      3'd2: begin tw_c = '0;   tw_s = -ONE; end
      3'd3: begin tw_c = -R2;  tw_s = -R2;  end
      3'd4: begin tw_c = -ONE; tw_s = '0;   end
      3'd5: begin tw_c = -R2;  tw_s = R2;   end
      3'd6: begin tw_c = '0;   tw_s = ONE;  end
      default: begin tw_c = R2; tw_s = R2; end
    endcase
  end

  assign p_ac = a * tw_c;
  assign p_bs = b * tw_s;
  assign p_as = a * tw_s;
  assign p_bc = b * tw_c;

  assign acc_re_next = acc_re + AW'(p_ac >>> FB) - AW'(p_bs >>> FB);
  assign acc_im_next = acc_im + AW'(p_as >>> FB) + AW'(p_bc >>> FB);

  assign sc_re  = acc_re * SC;
  assign sc_im  = acc_im * SC;
  assign res_re = sat(sc_re);
  assign res_im = sat(sc_im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= '0;
      k_cnt    <= '0;
      out_cnt  <= '0;
      step     <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (io.in_valid) begin
            load_cnt <= load_cnt + 3'd1;
            if (load_cnt == 3'd7) begin
              state  <= COMPUTE;
              k_cnt  <= '0;
              step   <= '0;
              acc_re <= '0;
              acc_im <= '0;
            end
          end
        end
        COMPUTE: begin
          if (scale_step) begin
            step   <= '0;
            acc_re <= '0;
            acc_im <= '0;
            k_cnt  <= k_cnt + 3'd1;
            if (k_cnt == 3'd7) begin
              state   <= OUTPUT;
              out_cnt <= '0;
            end
          end else begin
            step   <= step + 4'd1;
            acc_re <= acc_re_next;
            acc_im <= acc_im_next;
          end
        end
        OUTPUT: begin
          if (io.out_ready) begin
            out_cnt <= out_cnt + 3'd1;
            if (out_cnt == 3'd7) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Sample storage carries no reset; outputs below are gated by state instead
  always_ff @(posedge clk) begin
    if (state == LOAD && io.in_valid) begin
      in_re_buf[load_cnt] <= io.in_re;
      in_im_buf[load_cnt] <= io.in_im;
    end
    if (state == COMPUTE && scale_step) begin
      out_re_buf[k_cnt] <= res_re;
      out_im_buf[k_cnt] <= res_im;
    end
  end

  assign io.in_ready  = (state == LOAD);
  assign io.out_valid = (state == OUTPUT);
  assign io.busy      = (state != LOAD);
  assign io.out_re    = (state == OUTPUT) ? out_re_buf[out_cnt] : '0;
  assign io.out_im    = (state == OUTPUT) ? out_im_buf[out_cnt] : '0;
  assign io.out_idx   = (state == OUTPUT) ? out_cnt : 3'd0;
  assign io.out_last  = (state == OUTPUT) && (out_cnt == 3'd7);
endmodule

// File: tb/tb_iqft_engine.sv
// Testbench for iqft_engine: a fixed-point model fills a scoreboard queue per frame, and every
// output beat is popped and compared, plus accuracy, timing, stall and reset scenarios.
module tb_iqft_engine;
  typedef logic signed [16:0] amp_t;
  typedef struct {
    amp_t       re;
    amp_t       im;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  exp_t q[$];
  amp_t got_re[8];
  amp_t got_im[8];

  iqft_engine_if #(.DW(17)) bus ();

  iqft_engine #(.DW(17), .SCALE(11585), .RT2(23170)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wrap20(input longint x);
    longint y;
    y = x & 64'hFFFFF;
    if (y >= 64'sd524288) y = y - 64'sd1048576;
    return y;
  endfunction

  // Fixed-point inverse DFT with per-product truncation, 20-bit accumulators, scale and saturation
  function automatic void push_expected(input amp_t ar[8], input amp_t ai[8]);
    int     ct[8];
    int     st[8];
    longint are, aim, a, b, r;
    int     mm;
    exp_t   e;
    ct = '{32768, 23170, 0, -23170, -32768, -23170, 0, 23170};
    st = '{0, -23170, -32768, -23170, 0, 23170, 32768, 23170};
    for (int k = 0; k < 8; k++) begin
      are = 0;
      aim = 0;
      for (int j = 0; j < 8; j++) begin
        mm  = (j * k) % 8;
        a   = longint'(ar[j]);
        b   = longint'(ai[j]);
        are = wrap20(are + ((a * ct[mm]) >>> 15) - ((b * st[mm]) >>> 15));
        aim = wrap20(aim + ((a * st[mm]) >>> 15) + ((b * ct[mm]) >>> 15));
      end
      r = (are * 11585) >>> 15;
      if (r > 65535) r = 65535;
      if (r < -65536) r = -65536;
      e.re = amp_t'(r);
      r = (aim * 11585) >>> 15;
      if (r > 65535) r = 65535;
      if (r < -65536) r = -65536;
      e.im   = amp_t'(r);
      e.idx  = 3'(k);
      e.last = (k == 7);
      q.push_back(e);
    end
  endfunction

  task automatic send_frame(input amp_t ar[8], input amp_t ai[8]);
    int n;
    push_expected(ar, ai);
    for (int j = 0; j < 8; j++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = ar[j];
      bus.in_im    = ai[j];
      n = 0;
      while (!bus.in_ready && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 200) begin
        n_vec++;
        n_bad++;
        $display("[TB] FAIL in_ready_timeout beat=%0d got in_ready=%b want 1", j, bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Pops one scoreboard entry per beat; optionally stalls at beat stall_k for stall_len cycles
  task automatic recv_frame(input int stall_k, input int stall_len);
    int   n;
    exp_t e;
    bus.out_ready = 1'b1;
    for (int bt = 0; bt < 8; bt++) begin
      n = 0;
      while (!bus.out_valid && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      n_vec++;
      if (n >= 200 || q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL out_valid_wait beat=%0d got valid=%b queued=%0d want valid=1 with data queued",
                 bt, bus.out_valid, q.size());
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        return;
      end
      e = q.pop_front();
      if (bt == stall_k) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk);
          #1;
          n_vec++;
          if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_idx} !== {1'b1, e.re, e.im, e.idx}) begin
            n_bad++;
            $display("[TB] FAIL stall_hold beat=%0d got v=%b re=%0d im=%0d idx=%0d want v=1 re=%0d im=%0d idx=%0d",
                     bt, bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, e.re, e.im, e.idx);
          end
        end
        bus.out_ready = 1'b1;
      end
      if ({bus.out_re, bus.out_im, bus.out_idx, bus.out_last} !== {e.re, e.im, e.idx, e.last}) begin
        n_bad++;
        $display("[TB] FAIL beat k=%0d got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d last=%b",
                 bt, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, e.re, e.im, e.idx, e.last);
      end
      got_re[bt] = bus.out_re;
      got_im[bt] = bus.out_im;
      if (bt == 7) bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      n_bad++;
      $display("[TB] FAIL frame_end got valid=%b in_ready=%b busy=%b want 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic basis_vec(output amp_t ar[8], output amp_t ai[8]);
    for (int j = 0; j < 8; j++) begin
      ar[j] = '0;
      ai[j] = '0;
    end
    ar[0] = 17'sd32768;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.busy}
        !== {1'b1, 1'b0, 17'sd0, 17'sd0, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL reset_state got rdy=%b v=%b re=%0d im=%0d idx=%0d last=%b busy=%b want 1 0 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.busy);
    end
  endtask

  task automatic test_basis();
    amp_t ar[8], ai[8];
    basis_vec(ar, ai);
    send_frame(ar, ai);
    recv_frame(-1, 0);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (got_re[k] !== 17'sd11585 || got_im[k] !== 17'sd0) begin
        n_bad++;
        $display("[TB] FAIL basis_value k=%0d got (%0d,%0d) want (11585,0)", k, got_re[k], got_im[k]);
      end
    end
  endtask

  task automatic test_uniform();
    amp_t ar[8], ai[8];
    for (int j = 0; j < 8; j++) begin
      ar[j] = 17'sd11585;
      ai[j] = 17'sd0;
    end
    send_frame(ar, ai);
    recv_frame(-1, 0);
    n_vec++;
    if (got_re[0] < 32765 || got_re[0] > 32767 || got_im[0] != 0) begin
      n_bad++;
      $display("[TB] FAIL uniform_dc got (%0d,%0d) want (32766+-1,0)", got_re[0], got_im[0]);
    end
    for (int k = 1; k < 8; k++) begin
      n_vec++;
      if (got_re[k] > 4 || got_re[k] < -4 || got_im[k] > 4 || got_im[k] < -4) begin
        n_bad++;
        $display("[TB] FAIL uniform_leak k=%0d got (%0d,%0d) want |re|,|im| <= 4", k, got_re[k], got_im[k]);
      end
    end
  endtask

  // Forward-QFT coefficients of |5>: (1/sqrt8) * W^(5j)
  task automatic test_round_trip();
    amp_t ar[8], ai[8];
    ar = '{17'sd11585, -17'sd8192, 17'sd0, 17'sd8192, -17'sd11585, 17'sd8192, 17'sd0, -17'sd8192};
    ai = '{17'sd0, -17'sd8192, 17'sd11585, -17'sd8192, 17'sd0, 17'sd8192, -17'sd11585, 17'sd8192};
    send_frame(ar, ai);
    recv_frame(-1, 0);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (k == 5) begin
        if (got_re[5] < 32760 || got_re[5] > 32776 || got_im[5] > 8 || got_im[5] < -8) begin
          n_bad++;
          $display("[TB] FAIL round_trip_peak got (%0d,%0d) want (32768+-8, |im|<=8)", got_re[5], got_im[5]);
        end
      end else if (got_re[k] > 8 || got_re[k] < -8 || got_im[k] > 8 || got_im[k] < -8) begin
        n_bad++;
        $display("[TB] FAIL round_trip_leak k=%0d got (%0d,%0d) want |re|,|im| <= 8", k, got_re[k], got_im[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    amp_t ar[8], ai[8];
    for (int j = 0; j < 8; j++) begin
      ar[j] = amp_t'(j * 3000 - 10000);
      ai[j] = amp_t'(5000 - j * 1700);
    end
    send_frame(ar, ai);
    recv_frame(3, 5);
  endtask

  task automatic test_reset_mid_compute();
    amp_t ar[8], ai[8];
    for (int j = 0; j < 8; j++) begin
      ar[j] = 17'sd20000;
      ai[j] = -17'sd7000;
    end
    send_frame(ar, ai);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    n_vec++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.out_idx} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_during got v=%b busy=%b rdy=%b idx=%0d want 0 0 1 0",
               bus.out_valid, bus.busy, bus.in_ready, bus.out_idx);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_after got v=%b busy=%b rdy=%b want 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    test_basis();
  endtask

  // Cycle 1 is the one right after the 8th transfer edge; OUTPUT is the 73rd, visible after 72 edges
  task automatic test_junk_and_latency();
    amp_t ar[8], ai[8];
    int   n;
    basis_vec(ar, ai);
    send_frame(ar, ai);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      bus.in_re = amp_t'($urandom);
      bus.in_im = amp_t'($urandom);
      @(posedge clk);
      #1;
      n++;
      if (n == 10) begin
        n_vec++;
        if ({bus.in_ready, bus.busy} !== 2'b01) begin
          n_bad++;
          $display("[TB] FAIL compute_status got rdy=%b busy=%b want 0 1", bus.in_ready, bus.busy);
        end
      end
    end
    n_vec++;
    if (n != 72) begin
      n_bad++;
      $display("[TB] FAIL latency got %0d edges want 72 (out_valid in cycle 73)", n);
    end
    recv_frame(-1, 0);
  endtask

  task automatic test_back_to_back();
    test_uniform();
    test_basis();
  endtask

  initial begin
    n_vec         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basis();
    test_uniform();
    test_round_trip();
    test_backpressure();
    test_reset_mid_compute();
    test_junk_and_latency();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
